lsu: RTL and testbench

Load/store unit for the MEM stage of the pipelined RISC-V core. It sits directly upstream of the unified word-addressed memory (256 × 32-bit, combinational read, write on rising clock edge, no byte enables) and turns RV32I load/store requests (LB/LH/LW/LBU/LHU/SB/SH/SW) into word accesses. Loads are extracted and extended combinationally in the same cycle. SB/SH are done as a two-cycle read-modify-write with a pipeline stall. Misaligned or illegal requests are blocked and flagged.

---
 rtl/lsu_if.sv | 28 ++
 rtl/lsu.sv | 148 ++++++++++++++
 tb/tb_lsu.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Bundle between the MEM stage, the load/store unit and the word-addressed memory.
// The slave modport is the LSU's view; the master modport is the pipeline plus memory.
interface lsu_if;
    logic        req_read;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata_out;
    logic        stall;
    logic        fault;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Requests are level-held by the pipeline; while stall=1 the inputs stay frozen,
    // and a store is taken exactly once on the edge where stall=0.
    modport slave (
        input  req_read, req_write, funct3, addr, wdata, mem_rd,
        output rdata_out, stall, fault, mem_we, mem_a, mem_wd
    );

    modport master (
        output req_read, req_write, funct3, addr, wdata, mem_rd,
        input  rdata_out, stall, fault, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/lsu.sv
// RV32I load/store unit: same-cycle loads and SW, two-cycle read-modify-write for SB/SH.
// Outputs are combinational from state and inputs; reset forces all strobes low at once.
module lsu (
    input  logic  clk,
    input  logic  reset,
    lsu_if.slave  bus,
    output logic  o_dbg_state
);
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_merged;
    logic [31:0] r_waddr;

    logic        w_store;
    logic        w_load;
    logic        w_legal;
    logic        w_misal;
    logic        w_fault;
    logic        w_sub_store;
    logic [31:0] w_word_a;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    // A simultaneous read+write request is handled as a store.
    assign w_store  = bus.req_write;
    assign w_load   = bus.req_read & ~bus.req_write;
    assign w_word_a = {bus.addr[31:2], 2'b00};

    always_comb begin
        w_legal = 1'b0;
        if (w_store) begin
            w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010);
        end else if (w_load) begin
            w_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                      (bus.funct3 == 3'b010) || (bus.funct3 == 3'b100) ||
                      (bus.funct3 == 3'b101);
        end
    end

    always_comb begin
        case (bus.funct3[1:0])
            2'b01:   w_misal = bus.addr[0];
            2'b10:   w_misal = (bus.addr[1:0] != 2'b00);
            default: w_misal = 1'b0;
        endcase
    end

    assign w_fault     = (w_store | w_load) & (~w_legal | w_misal);
    assign w_sub_store = w_store & ~w_fault & ~bus.funct3[1];

    // Lane select is one 4:1 mux deep so it adds little after the memory read path.
    always_comb begin
        case (bus.addr[1:0])
            2'b00:   w_byte = bus.mem_rd[7:0];
            2'b01:   w_byte = bus.mem_rd[15:8];
            2'b10:   w_byte = bus.mem_rd[23:16];
            default: w_byte = bus.mem_rd[31:24];
        endcase
        w_half = bus.addr[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
    end

    always_comb begin
        case (bus.funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'd0, w_half};
            3'b010:  w_load_data = bus.mem_rd;
            default: w_load_data = 32'd0;
        endcase
    end

    always_comb begin
        w_merged = bus.mem_rd;
        if (bus.funct3[0]) begin
            w_merged[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
        end else begin
            w_merged[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_merged <= 32'd0;
            r_waddr  <= 32'd0;
        end else if ((r_state == S_IDLE) && w_sub_store) begin
            r_merged <= w_merged;
            r_waddr  <= w_word_a;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_sub_store ? S_WRITE : S_IDLE;
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_we    = 1'b0;
        bus.stall     = 1'b0;
        bus.fault     = 1'b0;
        bus.rdata_out = 32'd0;
        bus.mem_a     = w_word_a;
        bus.mem_wd    = bus.wdata;
        if (!reset) begin
            case (r_state)
                S_IDLE: begin
                    bus.fault = w_fault;
                    if (!w_fault) begin
                        if (w_load) begin
                            bus.rdata_out = w_load_data;
                        end else if (w_store) begin
                            bus.stall  = w_sub_store;
                            bus.mem_we = ~w_sub_store;
                        end
                    end
                end
                S_WRITE: begin
                    bus.mem_we = 1'b1;
                    bus.mem_a  = r_waddr;
                    bus.mem_wd = r_merged;
                end
                default: ;
            endcase
        end
    end

    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed steps from the test plan, then random requests checked
// against a byte-level reference model of RV32I load/store semantics.
module tb_lsu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic dbg_state;

    lsu_if bus ();

    lsu u_dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_a  = 8'd0;
    logic [31:0] pre_d  = 32'd0;

    assign bus.mem_rd = tb_mem[bus.mem_a[9:2]];

    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_a[9:2]] <= bus.mem_wd;
        else if (pre_we) tb_mem[pre_a] <= pre_d;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] a);
        logic [31:0] v;
        v = word >> (8 * a[1:0]);
        case (f3)
            3'd0: return 32'($signed(v[7:0]));
            3'd4: return {24'd0, v[7:0]};
            3'd1: return 32'($signed(v[15:0]));
            3'd5: return {16'd0, v[15:0]};
            default: return word;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        mask = ((f3 == 3'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << (8 * a[1:0]);
        return (word & ~mask) | ((d << (8 * a[1:0])) & mask);
    endfunction

    function automatic logic ref_fault(input logic rd, input logic wr, input logic [2:0] f3,
                                       input logic [31:0] a);
        logic legal;
        int   bytes;
        if (!rd && !wr) return 1'b0;
        legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        bytes = 1 << f3[1:0];
        return !legal || ((a % bytes) != 0);
    endfunction

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_read  = rd;
        bus.req_write = wr;
        bus.funct3    = f3;
        bus.addr      = a;
        bus.wdata     = d;
    endtask

    // One complete request: drive, check every cycle against the model, advance memory.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, output logic [31:0] obs);
        logic        flt;
        logic [7:0]  widx;
        logic [31:0] exp_rd;
        logic [31:0] exp_word;
        flt  = ref_fault(rd, wr, f3, a);
        widx = a[9:2];
        exp_rd = 32'd0;
        if (rd && !wr && !flt) exp_rd = ref_load(ref_mem[widx], f3, a);
        drive(rd, wr, f3, a, d);
        @(negedge clk);
        obs = bus.rdata_out;
        check("fault", {31'd0, bus.fault}, {31'd0, flt});
        check("mem_a", bus.mem_a, {a[31:2], 2'b00});
        check("rdata_out", bus.rdata_out, exp_rd);
        if (wr && !flt && f3 != 3'd2) begin
            check("rmw1_stall", {31'd0, bus.stall}, 32'd1);
            check("rmw1_we", {31'd0, bus.mem_we}, 32'd0);
            exp_word = ref_merge(ref_mem[widx], f3, a, d);
            @(posedge clk); #1;
            @(negedge clk);
            obs = bus.mem_wd;
            check("rmw2_state", {31'd0, dbg_state}, 32'd1);
            check("rmw2_we", {31'd0, bus.mem_we}, 32'd1);
            check("rmw2_stall", {31'd0, bus.stall}, 32'd0);
            check("rmw2_fault", {31'd0, bus.fault}, 32'd0);
            check("rmw2_mem_a", bus.mem_a, {a[31:2], 2'b00});
            check("rmw2_wd", bus.mem_wd, exp_word);
            ref_mem[widx] = exp_word;
        end else begin
            check("stall", {31'd0, bus.stall}, 32'd0);
            if (wr && !flt) begin
                obs = bus.mem_wd;
                check("sw_we", {31'd0, bus.mem_we}, 32'd1);
                check("sw_wd", bus.mem_wd, d);
                ref_mem[widx] = d;
            end else begin
                check("we_off", {31'd0, bus.mem_we}, 32'd0);
            end
        end
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'd0, a, 32'd0);
        if (rd || wr) check("mem_word", tb_mem[widx], ref_mem[widx]);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        logic [2:0]  f3;
        int          kind;

        drive(1'b1, 1'b0, 3'd2, 32'h100, 32'd0);
        #2;
        check("rst_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_fault", {31'd0, bus.fault}, 32'd0);
        check("rst_rdata", bus.rdata_out, 32'd0);
        check("rst_state", {31'd0, dbg_state}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);

        // Preload words 0x100..0x13C while reset holds the DUT quiet.
        for (int i = 64; i < 80; i++) begin
            pre_we = 1'b1;
            pre_a  = 8'(i);
            pre_d  = (i == 64) ? 32'h8899_AABB : $urandom();
            ref_mem[i] = pre_d;
            @(posedge clk); #1;
        end
        pre_we = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, obs);
        check("lb_103", obs, 32'hFFFF_FF88);
        run_op(1'b1, 1'b0, 3'd4, 32'h101, 32'd0, obs);
        check("lbu_101", obs, 32'h0000_00AA);
        run_op(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, obs);
        check("lh_102", obs, 32'hFFFF_8899);

        run_op(1'b0, 1'b1, 3'd0, 32'h101, 32'h1234_5677, obs);
        check("sb_101_wd", obs, 32'h8899_77BB);
        run_op(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, obs);
        check("lw_after_sb", obs, 32'h8899_77BB);
        run_op(1'b0, 1'b1, 3'd1, 32'h102, 32'h0000_CAFE, obs);
        check("sh_102_wd", obs, 32'hCAFE_77BB);
        run_op(1'b0, 1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, obs);
        check("sw_104_mem", tb_mem[65], 32'hDEAD_BEEF);

        run_op(1'b1, 1'b0, 3'd2, 32'h102, 32'd0, obs);
        run_op(1'b0, 1'b1, 3'd1, 32'h103, 32'h0000_5555, obs);
        run_op(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, obs);

        // Reset lands in the WRITE cycle of an SB: the write must not happen.
        drive(1'b0, 1'b1, 3'd0, 32'h100, 32'h0000_0011);
        @(posedge clk); #1;
        check("pre_rst_state", {31'd0, dbg_state}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_we", {31'd0, bus.mem_we}, 32'd0);
        check("midrst_state", {31'd0, dbg_state}, 32'd0);
        check("midrst_stall", {31'd0, bus.stall}, 32'd0);
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_word", tb_mem[64], 32'hCAFE_77BB);
        check("post_rst_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        run_op(1'b0, 1'b1, 3'd0, 32'h100, 32'h0000_0055, obs);
        check("sb_after_rst", tb_mem[64], 32'hCAFE_7755);

        run_op(1'b1, 1'b1, 3'd2, 32'h108, 32'h1122_3344, obs);
        check("rw_sw_mem", tb_mem[66], 32'h1122_3344);

        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 3);
            f3   = 3'($urandom_range(0, 7));
            a    = ($urandom() & 32'hFFFF_FC00) | (32'h100 + $urandom_range(0, 63));
            run_op(kind == 1 || kind == 3, kind >= 2, f3, a, $urandom(), obs);
        end

        for (int i = 64; i < 80; i++) check("final_mem", tb_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
